percep_infer_seq: RTL and testbench

//  Parametrised perceptron inference sequencer, next generation of the fixed 5-attribute / 20-sample flow.
//  - Load phase: streams INFER_NUM*ATTR ydx words into the external ydx memory, then ATTR weights into an internal register file.
//  - Compute phase: drives an external FP16 MAC once per sample, derives ya, compares it with yd and counts mismatches.
//  - Reports done, fail and mismatch count. Sits between the data loader and the FP MAC inside percep_top.

---
 rtl/percep_infer_seq_if.sv | 37 +++
 rtl/percep_infer_seq.sv | 103 ++++++++++
 tb/tb_percep_infer_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/percep_infer_seq_if.sv
// percep_infer_seq_if: load stream, ydx memory, FP MAC and result signals of the perceptron sequencer
interface percep_infer_seq_if #(
  parameter int MEM_WIDTH_YDX = 17,
  parameter int MEM_ADDR_YDX  = 7,
  parameter int FP_WIDTH      = 16
);
  logic                     infer_ena;
  logic                     d_vld;
  logic [MEM_WIDTH_YDX-1:0] d_txt_in;
  logic                     mem_we;
  logic [MEM_ADDR_YDX-1:0]  mem_addr;
  logic [MEM_WIDTH_YDX-1:0] mem_wdata;
  logic [MEM_WIDTH_YDX-1:0] mem_rdata;
  logic                     mac_vld;
  logic                     mac_last;
  logic [FP_WIDTH-1:0]      mac_x;
  logic [FP_WIDTH-1:0]      mac_w;
  logic                     mac_rdy;
  logic                     net_vld;
  logic [FP_WIDTH-1:0]      net;
  logic                     res_vld;
  logic                     ya;
  logic                     yd;
  logic [MEM_ADDR_YDX-1:0]  err_cnt;
  logic                     infer_done;
  logic                     infer_fail;
  modport master (
    input  infer_ena, d_vld, d_txt_in, mem_rdata, mac_rdy, net_vld, net,
    output mem_we, mem_addr, mem_wdata, mac_vld, mac_last, mac_x, mac_w,
           res_vld, ya, yd, err_cnt, infer_done, infer_fail
  );
  modport slave (
    output infer_ena, d_vld, d_txt_in, mem_rdata, mac_rdy, net_vld, net,
    input  mem_we, mem_addr, mem_wdata, mac_vld, mac_last, mac_x, mac_w,
           res_vld, ya, yd, err_cnt, infer_done, infer_fail
  );
endinterface

// File: rtl/percep_infer_seq.sv
// percep_infer_seq: loads ydx samples and weights, drives an FP16 MAC per sample and counts class mismatches
module percep_infer_seq #(
  parameter int MEM_WIDTH_YDX = 17,
  parameter int MEM_ADDR_YDX  = 7,
  parameter int ATTR          = 5,
  parameter int INFER_NUM     = 20,
  parameter int FP_WIDTH      = 16,
  parameter int FAIL_THR      = 20
) (
  input logic clk,
  input logic rst,
  percep_infer_seq_if.master bus
);
  localparam int AW = $clog2(ATTR);
  localparam int NW = INFER_NUM * ATTR;
  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_W, RD, ISSUE, WAIT_NET, CMP, DONE} state_t;
  state_t state, nxt;
  logic ena_q, rd_q, yd_q, ya_q;
  logic [MEM_ADDR_YDX-1:0] cnt, s, err_q, rd_addr;
  logic [AW-1:0] a, wk;
  logic [FP_WIDTH-1:0] x_q;
  logic [FP_WIDTH-1:0] wreg [ATTR];
  logic abort, hs, last_a, mis;
  assign abort   = state != IDLE && state != DONE && !bus.infer_ena;
  assign last_a  = a == AW'(ATTR - 1);
  assign hs      = state == ISSUE && bus.mac_rdy;
  assign mis     = ya_q != yd_q;
  assign rd_addr = MEM_ADDR_YDX'(s * ATTR) + MEM_ADDR_YDX'(a);
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (bus.infer_ena && !ena_q) nxt = LOAD_X;
      LOAD_X:   if (bus.d_vld && cnt == MEM_ADDR_YDX'(NW - 1)) nxt = LOAD_W;
      LOAD_W:   if (bus.d_vld && wk == AW'(ATTR - 1)) nxt = RD;
      RD:       nxt = ISSUE;
      ISSUE:    if (bus.mac_rdy) nxt = last_a ? WAIT_NET : RD;
      WAIT_NET: if (bus.net_vld) nxt = CMP;
      CMP:      nxt = s == MEM_ADDR_YDX'(INFER_NUM - 1) ? DONE : RD;
      DONE:     if (!bus.infer_ena) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ena_q <= 1'b0;
      rd_q  <= 1'b0;
      yd_q  <= 1'b0;
      ya_q  <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      err_q <= '0;
      a     <= '0;
      wk    <= '0;
      x_q   <= '0;
      for (int i = 0; i < ATTR; i++) wreg[i] <= '0;
    end else begin
      ena_q <= bus.infer_ena;
      rd_q  <= state == RD;
      if (nxt == IDLE) begin
        cnt   <= '0;
        s     <= '0;
        a     <= '0;
        wk    <= '0;
        err_q <= '0;
      end else begin
        if (state == LOAD_X && bus.d_vld) cnt <= cnt + 1'b1;
        if (state == LOAD_W && bus.d_vld) begin
          wreg[wk] <= bus.d_txt_in[FP_WIDTH-1:0];
          wk       <= wk + 1'b1;
        end
        // first ISSUE cycle: RAM data is fresh, freeze it for the stall
        if (rd_q) begin
          x_q <= bus.mem_rdata[FP_WIDTH-1:0];
          if (a == '0) yd_q <= bus.mem_rdata[MEM_WIDTH_YDX-1];
        end
        if (hs && !last_a) a <= a + 1'b1;
        if (state == WAIT_NET && bus.net_vld) ya_q <= ~bus.net[FP_WIDTH-1];
        if (state == CMP) begin
          err_q <= (mis && err_q != '1) ? err_q + 1'b1 : err_q;
          s     <= s + 1'b1;
          a     <= '0;
        end
      end
    end
  end
  always_comb begin
    bus.mem_we     = !rst && state == LOAD_X && bus.d_vld && bus.infer_ena;
    bus.mem_addr   = state == LOAD_X ? cnt : (state == RD || state == ISSUE) ? rd_addr : '0;
    bus.mem_wdata  = state == LOAD_X ? bus.d_txt_in : '0;
    bus.mac_vld    = !rst && state == ISSUE && bus.infer_ena;
    bus.mac_last   = bus.mac_vld && last_a;
    bus.mac_x      = state != ISSUE ? '0 : rd_q ? bus.mem_rdata[FP_WIDTH-1:0] : x_q;
    bus.mac_w      = state == ISSUE ? wreg[a] : '0;
    bus.res_vld    = state == CMP;
    bus.ya         = ya_q;
    bus.yd         = yd_q;
    bus.err_cnt    = err_q;
    bus.infer_done = state == DONE;
    bus.infer_fail = state == DONE && err_q >= MEM_ADDR_YDX'(FAIL_THR);
  end
endmodule

// File: tb/tb_percep_infer_seq.sv
// tb_percep_infer_seq: table-driven runs with RAM and MAC models plus reset and abort sequences
module tb_percep_infer_seq;
  localparam int ATTR = 5;
  localparam int INUM = 20;
  localparam int NW   = ATTR * INUM;
  typedef struct {
    logic [19:0] inv;
    int          rg;
    int          dg;
    bit          em;
    int          err;
    bit          fail;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  percep_infer_seq_if bus ();
  percep_infer_seq #(.FAIL_THR(20)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [16:0] mem [128];
  logic [16:0] dat [NW];
  logic [15:0] wt [ATTR];
  int total = 0, bad = 0;
  int pidx = 0, rcnt = 0, wcnt = 0, rdy_gap = 0, stall = 0, cyc = 0, last_res = 0;
  logic [19:0] inv = '0;
  bit em = 0, hold7 = 0, pend = 0;
  logic [15:0] pend_net = '0;
  rec_t tbl [6];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // MAC model, write monitor and result checker, all acting on the falling edge
  initial begin
    int s;
    logic y;
    bus.mac_rdy = 1'b0;
    bus.net_vld = 1'b0;
    bus.net     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.net_vld = pend;
      bus.net     = pend_net;
      pend        = 1'b0;
      if (bus.mem_we) begin
        chk("wr_addr", bus.mem_addr, wcnt);
        chk("wr_data", bus.mem_wdata, wcnt < NW ? dat[wcnt] : 17'h0);
        wcnt++;
      end
      if (bus.res_vld && rcnt < INUM) begin
        chk("yd", bus.yd, dat[rcnt*ATTR][16]);
        chk("ya", bus.ya, dat[rcnt*ATTR][16] ^ inv[rcnt]);
        if (rdy_gap == 0 && rcnt > 0) chk("period", cyc - last_res, 2 * ATTR + 2);
        last_res = cyc;
        rcnt++;
      end
      bus.mac_rdy = stall >= rdy_gap ? 1'b1 : 1'($urandom_range(0, 1));
      stall = bus.mac_rdy ? 0 : stall + 1;
      if (bus.mac_vld && pidx < NW) begin
        chk("mac_x", bus.mac_x, dat[pidx][15:0]);
        chk("mac_w", bus.mac_w, wt[pidx%ATTR]);
        chk("mac_last", bus.mac_last, pidx % ATTR == ATTR - 1);
        if (bus.mac_rdy) begin
          s = pidx / ATTR;
          if (pidx % ATTR == ATTR - 1 && !(hold7 && s == 7)) begin
            y = dat[s*ATTR][16] ^ inv[s];
            pend = 1'b1;
            pend_net = y ? (em ? 16'h0000 : 16'h3C00) : (em ? 16'h8000 : 16'hBC00);
          end
          pidx++;
        end
      end
    end
  end
  task automatic gen();
    for (int i = 0; i < NW; i++) dat[i] = 17'($urandom);
    for (int i = 0; i < ATTR; i++) wt[i] = 16'($urandom);
  endtask
  task automatic start(input int dg, input int nwords);
    pidx = 0;
    rcnt = 0;
    wcnt = 0;
    bus.infer_ena = 1'b1;
    tick();
    for (int i = 0; i < nwords; i++) begin
      repeat ($urandom_range(0, dg)) begin
        bus.d_vld = 1'b0;
        tick();
      end
      bus.d_vld = 1'b1;
      bus.d_txt_in = i < NW ? dat[i] : i < NW + ATTR ? {1'b0, wt[i-NW]} : 17'h1ABCD;
      tick();
    end
    bus.d_vld = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!bus.infer_done && n < 6000) begin
      tick();
      n++;
    end
    chk("done_timeout", bus.infer_done, 1);
  endtask
  task automatic run_rec(input rec_t r);
    int m = 0;
    rdy_gap = r.rg;
    inv = r.inv;
    em = r.em;
    gen();
    start(r.dg, NW + ATTR + 2);
    wait_done();
    chk("err_cnt", bus.err_cnt, r.err);
    chk("fail", bus.infer_fail, r.fail);
    chk("res_count", rcnt, INUM);
    for (int i = 0; i < NW; i++) if (mem[i] !== dat[i]) m++;
    chk("mem_contents", m, 0);
    tick();
    chk("done_held", {bus.infer_done, bus.infer_fail}, {1'b1, r.fail});
    bus.infer_ena = 1'b0;
    tick();
    chk("idle_after_done", {bus.infer_done, bus.err_cnt}, 8'h0);
  endtask
  initial begin
    int n;
    tbl[0] = '{inv: 20'h00000, rg: 0, dg: 0, em: 0, err: 0,  fail: 0};
    tbl[1] = '{inv: 20'hFFFFF, rg: 0, dg: 0, em: 0, err: 20, fail: 1};
    tbl[2] = '{inv: 20'h7FFFF, rg: 0, dg: 0, em: 0, err: 19, fail: 0};
    tbl[3] = '{inv: 20'h00421, rg: 4, dg: 3, em: 0, err: 3,  fail: 0};
    tbl[4] = '{inv: 20'h00005, rg: 0, dg: 0, em: 1, err: 2,  fail: 0};
    tbl[5] = '{inv: 20'h00000, rg: 2, dg: 1, em: 1, err: 0,  fail: 0};
    bus.infer_ena = 1'b0;
    bus.d_vld = 1'b0;
    bus.d_txt_in = '0;
    repeat (3) tick();
    chk("por_ctrl", {bus.mem_we, bus.mac_vld, bus.res_vld, bus.infer_done, bus.infer_fail,
                     bus.ya, bus.yd, bus.mem_addr, bus.err_cnt}, 0);
    rst = 1'b0;
    gen();
    start(0, 30);
    rst = 1'b1;
    bus.infer_ena = 1'b0;
    repeat (3) tick();
    chk("rst_ctrl", {bus.mem_we, bus.mac_vld, bus.res_vld, bus.infer_done, bus.infer_fail,
                     bus.ya, bus.yd, bus.mem_addr, bus.err_cnt}, 0);
    chk("rst_mac", {bus.mac_x, bus.mac_w}, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) run_rec(tbl[i]);
    rdy_gap = 0;
    inv = 20'h0000F;
    em = 0;
    hold7 = 1;
    gen();
    start(0, NW + ATTR);
    n = 0;
    while (pidx < 8 * ATTR && n < 2000) begin
      tick();
      n++;
    end
    chk("abort_reach", pidx, 8 * ATTR);
    chk("abort_pre_err", bus.err_cnt, 4);
    chk("abort_pre_done", bus.infer_done, 0);
    bus.infer_ena = 1'b0;
    tick();
    chk("abort_idle", {bus.infer_done, bus.mac_vld, bus.res_vld, bus.mem_we, bus.err_cnt}, 0);
    repeat (3) tick();
    chk("abort_res_count", rcnt, 7);
    chk("abort_no_done", bus.infer_done, 0);
    hold7 = 0;
    run_rec(tbl[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
